tsu_mc_stamper: RTL

//  Multi-channel start-of-packet time stamp unit, single clock domain. Detects SOP on NCH

---
 rtl/tsu_mc_stamper_if.sv | 27 ++
 rtl/tsu_mc_stamper.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/tsu_mc_stamper_if.sv
// Read/control bundle of the multi-channel SOP time stamp unit.
// The CPU/parser side uses the master modport; the stamper uses slave.
interface tsu_mc_stamper_if #(
    parameter int NCH  = 4,
    parameter int TS_W = 32,
    parameter int AW   = 4
);
    localparam int ID_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DW   = 8 + ID_W + TS_W;

    logic          q_clr;
    logic          q_rd_en;
    logic          q_rd_valid;
    logic [DW-1:0] q_rd_data;
    logic [AW:0]   q_rd_stat;
    logic [15:0]   ovf_cnt;

    modport master (
        output q_clr, q_rd_en,
        input  q_rd_valid, q_rd_data, q_rd_stat, ovf_cnt
    );

    modport slave (
        input  q_clr, q_rd_en,
        output q_rd_valid, q_rd_data, q_rd_stat, ovf_cnt
    );
endinterface

// File: rtl/tsu_mc_stamper.sv
// Multi-channel start-of-packet time stamper: per-channel SOP capture, round-robin
// arbitration and a shared show-ahead FIFO of {seq, channel, stamp}.
module tsu_mc_stamper #(
    parameter int NCH     = 4,
    parameter int TS_W    = 32,
    parameter int TS_ADJ  = 0,
    parameter int MIN_GAP = 5,
    parameter int AW      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   ch_ctrl,
    input  logic [TS_W-1:0]  rtc_time_in,
    tsu_mc_stamper_if.slave  rd
);
    localparam int ID_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DW    = 8 + ID_W + TS_W;
    localparam int DEPTH = 1 << AW;
    localparam int GW    = $clog2(MIN_GAP + 1);

    logic [NCH-1:0]  ctrl_q, ctrl_d1_q;
    logic [1:0]      arm_q;
    logic [GW-1:0]   gap_q      [NCH];
    logic [NCH-1:0]  pend_q;
    logic [TS_W-1:0] pend_ts_q  [NCH];
    logic [7:0]      pend_seq_q [NCH];
    logic [7:0]      seq_q      [NCH];
    logic [ID_W-1:0] rr_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     cnt_q, cnt_d;
    logic [15:0]     ovf_q, ovf_d;
    logic [DW-1:0]   mem [DEPTH];

    logic [NCH-1:0]  sop, drop, gnt_oh;
    logic            gnt_vld, wr_en, pop, full;
    logic [ID_W-1:0] gnt_id, idx;
    logic [4:0]      ndrop;
    logic [16:0]     ovf_sum;
    logic [TS_W-1:0] stamp;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign pop   = rd.q_rd_en && (cnt_q != '0);
    assign wr_en = gnt_vld && !full && !rd.q_clr;
    assign stamp = rtc_time_in + TS_W'(TS_ADJ);

    // arm_q keeps a channel held high across reset from looking like a fresh rising edge
    always_comb begin
        sop = '0;
        for (int unsigned i = 0; i < NCH; i++)
            sop[i] = arm_q[1] && ctrl_q[i] && !ctrl_d1_q[i] && (gap_q[i] == GW'(MIN_GAP));
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = ID_W'((32'(rr_q) + k) % NCH);
            if (!gnt_vld && pend_q[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = idx;
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        if (wr_en)
            gnt_oh[gnt_id] = 1'b1;
        drop  = sop & pend_q & ~gnt_oh;
        ndrop = '0;
        for (int unsigned i = 0; i < NCH; i++)
            ndrop = ndrop + {4'd0, drop[i]};
        ovf_sum = {1'b0, ovf_q} + {12'd0, ndrop};
        ovf_d   = ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
    end

    always_comb begin
        cnt_d = cnt_q;
        if (wr_en && !pop)
            cnt_d = cnt_q + (AW+1)'(1);
        else if (!wr_en && pop)
            cnt_d = cnt_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q    <= '0;
            ctrl_d1_q <= '0;
            arm_q     <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                gap_q[i]      <= GW'(MIN_GAP);
                pend_ts_q[i]  <= '0;
                pend_seq_q[i] <= '0;
                seq_q[i]      <= '0;
            end
        end else begin
            ctrl_q    <= ch_ctrl;
            ctrl_d1_q <= ctrl_q;
            arm_q     <= {arm_q[0], 1'b1};
            for (int unsigned i = 0; i < NCH; i++) begin
                if (ctrl_q[i])
                    gap_q[i] <= '0;
                else if (gap_q[i] != GW'(MIN_GAP))
                    gap_q[i] <= gap_q[i] + GW'(1);
                if (sop[i]) begin
                    seq_q[i] <= seq_q[i] + 8'd1;
                    if (!pend_q[i] || gnt_oh[i]) begin
                        pend_ts_q[i]  <= stamp;
                        pend_seq_q[i] <= seq_q[i];
                    end
                end
            end
        end
    end

    // A SOP landing in the q_clr cycle is discarded along with everything pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q   <= '0;
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= '0;
        end else if (rd.q_clr) begin
            pend_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= '0;
        end else begin
            pend_q <= (pend_q & ~gnt_oh) | sop;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
                rr_q     <= (gnt_id == ID_W'(NCH - 1)) ? '0 : gnt_id + ID_W'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_q] <= {pend_seq_q[gnt_id], gnt_id, pend_ts_q[gnt_id]};
    end

    assign rd.q_rd_valid = (cnt_q != '0);
    assign rd.q_rd_data  = (cnt_q != '0) ? mem[rd_ptr_q] : '0;
    assign rd.q_rd_stat  = cnt_q;
    assign rd.ovf_cnt    = ovf_q;
endmodule
